// File: rtl/rc5_pkg.sv
// rc5_pkg: definitions shared by the RC5 key-loading and key-unpacking blocks:
// FSM state encodings, the key byte order and the default key geometry.
package rc5_pkg;

  // Default key geometry shared with the key-loading block.
  localparam int RC5_B = 16;  // key length in bytes
  localparam int RC5_W = 32;  // word width in bits
  localparam int RC5_U = 4;   // bytes per word
  localparam int RC5_C = 4;   // number of L words, ceil(B/U)

  // Unpacker states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_SCRUB = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Byte order of key bytes inside an L word.
  typedef enum logic {
    BYTE_ORDER_LE = 1'b0,
    BYTE_ORDER_BE = 1'b1
  } byte_order_e;

  // Key byte i lives in byte (i mod U) of L[i/U], byte 0 being bits 7:0.
  localparam byte_order_e KEY_BYTE_ORDER = BYTE_ORDER_LE;

endpackage

// File: rtl/l_unpack.sv
// l_unpack: reads the RC5 L word array and writes the secret key back out as
// bytes K[0..B-1] into the key RAM (inverse of the key-loading step).
// Optional build macro L_UNPACK_SCRUB_EN: after the last byte of each word the
// word is overwritten with zero, so L is all zero when the readback completes.
module l_unpack
  import rc5_pkg::*;
#(
  parameter int B = RC5_B,
  parameter int W = RC5_W,
  parameter int U = RC5_U,
  parameter int C = RC5_C,
  localparam int B_length = (B > 1) ? $clog2(B) : 1,
  localparam int C_length = (C > 1) ? $clog2(C) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [C_length-1:0] L_address,
  input  logic [W-1:0]        L_sub_i,
  output logic                L_we,
  output logic [W-1:0]        L_data_o,
  output logic [B_length-1:0] key_address,
  output logic [7:0]          key_sub_o,
  output logic                key_we,
  output logic                busy,
  output logic                done
);

  // Byte index must be able to hold B itself (the terminal count).
  localparam int I_W = $clog2(B + 1);
  localparam int J_W = (U > 1) ? $clog2(U) : 1;

  localparam logic [I_W-1:0]      B_CNT  = I_W'(B);
  localparam logic [I_W-1:0]      I_ONE  = I_W'(1);
  localparam logic [J_W-1:0]      J_LAST = J_W'(U - 1);
  localparam logic [J_W-1:0]      J_ONE  = J_W'(1);
  localparam logic [C_length-1:0] L_ONE  = C_length'(1);

  // Byte that goes out next from a word held in the shift register.
  function automatic logic [7:0] lead_byte(input logic [W-1:0] w);
    return (KEY_BYTE_ORDER == BYTE_ORDER_LE) ? w[7:0] : w[W-1 -: 8];
  endfunction

  // Shift register after one byte has been consumed.
  function automatic logic [W-1:0] drop_byte(input logic [W-1:0] w);
    return (KEY_BYTE_ORDER == BYTE_ORDER_LE) ? (w >> 8) : (w << 8);
  endfunction

  state_e                state_q, state_d;
  logic [I_W-1:0]        i_q, i_d;        // key byte index
  logic [J_W-1:0]        j_q, j_d;        // byte position inside the current word
  logic [W-1:0]          shift_q, shift_d;
  logic [C_length-1:0]   l_addr_d;
  logic [B_length-1:0]   key_addr_d;
  logic [7:0]            key_data_d;
  logic                  key_we_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  last_byte;
  logic                  word_end;
`ifdef L_UNPACK_SCRUB_EN
  logic                  l_we_d;
`endif

  // The only data ever written back to L is zero.
  assign L_data_o = '0;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    shift_d    = shift_q;
    l_addr_d   = L_address;
    key_addr_d = key_address;
    key_data_d = key_sub_o;
    key_we_d   = 1'b0;
    done_d     = 1'b0;
    last_byte  = 1'b0;
    word_end   = 1'b0;
`ifdef L_UNPACK_SCRUB_EN
    l_we_d     = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          i_d      = '0;
          j_d      = '0;
          l_addr_d = '0;
        end
      end

      // Address is on the RAM; data appears during WAIT.
      ST_FETCH: state_d = ST_WAIT;

      ST_WAIT: begin
        state_d    = ST_EMIT;
        shift_d    = L_sub_i;
        key_we_d   = 1'b1;
        key_addr_d = i_q[B_length-1:0];
        key_data_d = lead_byte(L_sub_i);
      end

      ST_EMIT: begin
        i_d       = i_q + I_ONE;
        shift_d   = drop_byte(shift_q);
        last_byte = (i_d == B_CNT);
        word_end  = (j_q == J_LAST);
        j_d       = word_end ? '0 : j_q + J_ONE;
        if (!last_byte && !word_end) begin
          key_we_d   = 1'b1;
          key_addr_d = i_d[B_length-1:0];
          key_data_d = lead_byte(shift_d);
        end else begin
          // Upper bytes of a partial last word are simply dropped.
          j_d = '0;
`ifdef L_UNPACK_SCRUB_EN
          state_d = ST_SCRUB;
          l_we_d  = 1'b1;
`else
          if (last_byte) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_FETCH;
            l_addr_d = L_address + L_ONE;
          end
`endif
        end
      end

`ifdef L_UNPACK_SCRUB_EN
      // Word just emitted is being zeroed at the held address.
      ST_SCRUB: begin
        if (i_q == B_CNT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_FETCH;
          l_addr_d = L_address + L_ONE;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      shift_q     <= '0;
      L_address   <= '0;
      key_address <= '0;
      key_sub_o   <= '0;
      key_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      shift_q     <= shift_d;
      L_address   <= l_addr_d;
      key_address <= key_addr_d;
      key_sub_o   <= key_data_d;
      key_we      <= key_we_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef L_UNPACK_SCRUB_EN
  // L write strobe for the scrub cycle.
  always_ff @(posedge clk) begin
    if (rst) L_we <= 1'b0;
    else     L_we <= l_we_d;
  end
`else
  assign L_we = 1'b0;
`endif

endmodule

// File: tb/tb_l_unpack.sv
// tb_l_unpack: self-checking bench for l_unpack. Two instances: the default
// 16-byte geometry and a 10-byte key with a partial last word. Behavioural
// L RAM (1-cycle read) and key RAM models surround each instance.
`timescale 1ns/1ps
module tb_l_unpack;

`ifdef L_UNPACK_SCRUB_EN
  localparam int  DONE_A = 30;
  localparam int  DONE_B = 21;
  localparam bit  SCRUB  = 1'b1;
`else
  localparam int  DONE_A = 26;
  localparam int  DONE_B = 18;
  localparam bit  SCRUB  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel;              // 0: default instance, 1: B=10 instance
  logic ld_en;
  logic [127:0] ld_words; // L[0] in bits 31:0

  always #5 clk = ~clk;

  wire start_a = start && !sel;
  wire start_b = start && sel;

  // Instance A: defaults
  logic [1:0]  L_address_a;
  logic [31:0] L_sub_a, L_data_a;
  logic        L_we_a, key_we_a, busy_a, done_a;
  logic [3:0]  key_address_a;
  logic [7:0]  key_sub_a;

  l_unpack dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .L_address(L_address_a), .L_sub_i(L_sub_a), .L_we(L_we_a), .L_data_o(L_data_a),
    .key_address(key_address_a), .key_sub_o(key_sub_a), .key_we(key_we_a),
    .busy(busy_a), .done(done_a)
  );

  // Instance B: 10-byte key, 3 words
  logic [1:0]  L_address_b;
  logic [31:0] L_sub_b, L_data_b;
  logic        L_we_b, key_we_b, busy_b, done_b;
  logic [3:0]  key_address_b;
  logic [7:0]  key_sub_b;

  l_unpack #(.B(10), .W(32), .U(4), .C(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .L_address(L_address_b), .L_sub_i(L_sub_b), .L_we(L_we_b), .L_data_o(L_data_b),
    .key_address(key_address_b), .key_sub_o(key_sub_b), .key_we(key_we_b),
    .busy(busy_b), .done(done_b)
  );

  // RAM models and event counters
  logic [31:0] lmem_a [4];
  logic [31:0] lmem_b [4];
  logic [7:0]  kmem_a [16];
  logic [7:0]  kmem_b [16];
  int wr_a = 0, wr_b = 0, lwe_a = 0, lwe_b = 0;
  bit oob_b = 1'b0, dirty_a = 1'b0, dirty_b = 1'b0;

  always @(posedge clk) begin
    L_sub_a <= lmem_a[L_address_a];
    if (ld_en) begin
      for (int k = 0; k < 4; k++) lmem_a[k] <= ld_words[32*k +: 32];
    end else if (L_we_a) begin
      lmem_a[L_address_a] <= L_data_a;
      lwe_a <= lwe_a + 1;
      if (L_data_a != 0) dirty_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    L_sub_b <= lmem_b[L_address_b];
    if (ld_en) begin
      for (int k = 0; k < 4; k++) lmem_b[k] <= ld_words[32*k +: 32];
    end else if (L_we_b) begin
      lmem_b[L_address_b] <= L_data_b;
      lwe_b <= lwe_b + 1;
      if (L_data_b != 0) dirty_b <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < 16; k++) kmem_a[k] <= 8'h5A;
    end else if (key_we_a) begin
      kmem_a[key_address_a] <= key_sub_a;
      wr_a <= wr_a + 1;
    end
  end

  always @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < 16; k++) kmem_b[k] <= 8'h5A;
    end else if (key_we_b) begin
      kmem_b[key_address_b] <= key_sub_b;
      wr_b <= wr_b + 1;
      if (key_address_b >= 4'd10) oob_b <= 1'b1;
    end
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference key-loading step: L starts at zero, i from B-1 down to 0,
  // L[i/U] = rotl8(L[i/U]) + K[i]. Key packed with K[0] in bits 127:120.
  function automatic logic [127:0] key_load(input logic [127:0] kp);
    logic [31:0] l [4];
    for (int w = 0; w < 4; w++) l[w] = 32'h0;
    for (int i = 15; i >= 0; i--)
      l[i/4] = {l[i/4][23:0], l[i/4][31:24]} + {24'h0, kp[127-8*i -: 8]};
    return {l[3], l[2], l[1], l[0]};
  endfunction

  // Key RAM contents, K[0] in bits 127:120.
  function automatic logic [127:0] key_dump(input bit s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s ? kmem_b[i] : kmem_a[i];
    return r;
  endfunction

  task automatic prep(input logic [127:0] lw);
    @(negedge clk);
    ld_words = lw;
    ld_en    = 1'b1;
    @(negedge clk);
    ld_en    = 1'b0;
  endtask

  // One start pulse, optional re-pulses at cycles rp1/rp2 (cycle 1 = start
  // sample cycle); observes done/busy per cycle with a bounded wait.
  task automatic run(input bit s, input int rp1, input int rp2,
                     output int done_rel, output int done_cnt, output bit busy_bad);
    int rel;
    logic d, b;
    done_rel = -1; done_cnt = 0; busy_bad = 1'b0;
    sel = s;
    @(negedge clk);
    start = 1'b1;
    rel = 1;
    while (rel < 120 && !(done_rel > 0 && rel >= done_rel + 8)) begin
      @(negedge clk);
      rel++;
      start = (rel == rp1) || (rel == rp2);
      d = s ? done_b : done_a;
      b = s ? busy_b : busy_a;
      if (d) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      if (done_rel < 0 || rel == done_rel) begin
        if (!b) busy_bad = 1'b1;
      end else if (b) begin
        busy_bad = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [127:0] l_words;  // L[0] in bits 31:0
    logic [127:0] exp_key;  // K[0] in bits 127:120
  } vec_t;

  vec_t vecs [4];

  initial begin
    int dr, dc, w0, l0;
    bit bb;
    logic [127:0] key, lw;

    vecs[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'h00010203_04050607_08090A0B_0C0D0E0F};
    vecs[1] = '{128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF, 128'hEFBEADDE_67452301_EFCDAB89_0DF0FECA};
    vecs[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
    vecs[3] = '{128'h12345678_00FF00FF_00000000_80000001, 128'h01000080_00000000_FF00FF00_78563412};

    rst = 1'b1; start = 1'b0; sel = 1'b0; ld_en = 1'b0; ld_words = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {busy_a, done_a, key_we_a, L_we_a, key_address_a, key_sub_a, L_address_a, L_data_a}, '0);
    check("reset_outputs_b", {busy_b, done_b, key_we_b, L_we_b, key_address_b, key_sub_b, L_address_b, L_data_b}, '0);
    rst = 1'b0;

    // Table-driven default-geometry vectors
    for (int v = 0; v < 4; v++) begin
      prep(vecs[v].l_words);
      w0 = wr_a; l0 = lwe_a;
      run(1'b0, 0, 0, dr, dc, bb);
      check($sformatf("vec%0d_key", v), key_dump(1'b0), vecs[v].exp_key);
      check($sformatf("vec%0d_done_cycle", v), dr, DONE_A);
      check($sformatf("vec%0d_done_pulses", v), dc, 1);
      check($sformatf("vec%0d_busy_window", v), bb, 0);
      check($sformatf("vec%0d_key_writes", v), wr_a - w0, 16);
      check($sformatf("vec%0d_l_writes", v), lwe_a - l0, SCRUB ? 4 : 0);
      check($sformatf("vec%0d_l_after", v), {lmem_a[3], lmem_a[2], lmem_a[1], lmem_a[0]},
            SCRUB ? 128'h0 : vecs[v].l_words);
    end
    check("scrub_data_zero_a", dirty_a, 0);

    // Partial last word: B=10, C=3
    prep(128'hEEEEEEEE_DDCCBBAA_88776655_44332211);
    w0 = wr_b; l0 = lwe_b;
    run(1'b1, 0, 0, dr, dc, bb);
    check("b10_key", key_dump(1'b1), 128'h11223344_55667788_AABB5A5A_5A5A5A5A);
    check("b10_key_writes", wr_b - w0, 10);
    check("b10_no_oob_write", oob_b, 0);
    check("b10_done_cycle", dr, DONE_B);
    check("b10_done_pulses", dc, 1);
    check("b10_busy_window", bb, 0);
    check("b10_l_writes", lwe_b - l0, SCRUB ? 3 : 0);
    check("b10_l_after", {lmem_b[3], lmem_b[2], lmem_b[1], lmem_b[0]},
          SCRUB ? 128'hEEEEEEEE_00000000_00000000_00000000 : 128'hEEEEEEEE_DDCCBBAA_88776655_44332211);
    check("scrub_data_zero_b", dirty_b, 0);

    // Round trip through the reference key-loading step
    for (int r = 0; r < 3; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      lw  = key_load(key);
      prep(lw);
      run(1'b0, 0, 0, dr, dc, bb);
      check($sformatf("roundtrip%0d_key", r), key_dump(1'b0), key);
    end

    // start re-pulsed while busy and in the done cycle
    prep(vecs[0].l_words);
    w0 = wr_a;
    run(1'b0, 5, 26, dr, dc, bb);
    check("repulse_key_writes", wr_a - w0, 16);
    check("repulse_done_pulses", dc, 1);
    check("repulse_done_cycle", dr, DONE_A);

    // Reset during the second word's EMIT
    prep(vecs[1].l_words);
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);    // now in cycle 12
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {busy_a, done_a, key_we_a, L_we_a, key_address_a, key_sub_a, L_address_a, L_data_a}, '0);
    rst = 1'b0;
    w0 = wr_a;
    repeat (30) @(negedge clk);
    check("midrst_no_writes", wr_a - w0, 0);
    check("midrst_idle", busy_a, 0);
    prep(vecs[0].l_words);
    w0 = wr_a;
    run(1'b0, 0, 0, dr, dc, bb);
    check("postrst_key", key_dump(1'b0), vecs[0].exp_key);
    check("postrst_done_cycle", dr, DONE_A);
    check("postrst_key_writes", wr_a - w0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on simulated time
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/l_unpack.md
# l_unpack

Inverse of the RC5 key-loading step. The block reads the word array L[0..C-1] from the L RAM and writes the secret key back out as bytes K[0..B-1] into the key RAM, using the little-endian packing the key-loading step produces: K[i] = byte (i mod U) of L[i/U], where byte j is bits 8j+7:8j. It sits beside the key-loading block on the same two RAMs and is used for key readback and for round-trip verification of the key schedule.

## Interface
Parameters:
- B, 16, key length in bytes (1..255)
- W, 32, word width in bits; must equal 8*U
- U, 4, bytes per word
- C, 4, number of L words; must equal ceil(B/U)
- B_length = $clog2(B), C_length = $clog2(C) (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- L_address  out  C_length  L RAM read/write address
- L_sub_i  in  W  L RAM read data, valid one cycle after L_address
- L_we  out  1  L RAM write enable (scrub only)
- L_data_o  out  W  L RAM write data (scrub only, always 0)
- key_address  out  B_length  key RAM byte address
- key_sub_o  out  8  key RAM write data
- key_we  out  1  key RAM write enable
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at completion

## Operation
- All outputs are registered. Reset value of every output is 0. Internal state: byte index i = 0, shift register = 0, state = IDLE.
- States:
  - IDLE -> FETCH on start. Sets i=0 and L_address=0.
  - FETCH -> WAIT. Holds L_address.
  - WAIT -> EMIT. On the leaving edge, captures L_sub_i into the shift register. Drives key_we=1, key_address=i, key_sub_o=L_sub_i[7:0].
  - EMIT: each edge increments i and shifts the register right by 8.
    - If the next i < B and i mod U != 0, stay in EMIT and write the next byte.
    - Else if i == B, go to DONE.
    - Else go to FETCH (or SCRUB when enabled) with L_address+1.
  - DONE -> IDLE. done=1 for exactly this cycle; key_we=0.
- Partial last word (B mod U != 0): only bytes 0..(B mod U)-1 of L[C-1] are written. The upper bytes are discarded and no write occurs for key addresses >= B.
- start while busy or in DONE is ignored; start is not queued.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. No further RAM writes occur, and writes already issued are not undone.
- Inverse relation: a key loaded into a zeroed L array by the key-loading step (rotate-left-8 plus add, i from B-1 down to 0) unpacks to the identical byte sequence.

## Timing
- start sampled at edge 0 -> FETCH. The first key_we is high in the cycle after edge 2 (3 cycles of latency).
- Per word: 2 cycles (FETCH, WAIT) plus U EMIT cycles, or plus the valid byte count for a partial word. Add 1 cycle per word when scrubbing.
- Defaults: key_we is high for 16 cycles total. done pulses in cycle 26 counting the start-sample cycle as 1 (24 working cycles, then DONE).
- L RAM read latency is exactly 1 cycle. key RAM writes take effect on the edge where key_we=1.

## Configuration
- L_UNPACK_SCRUB_EN defined:
  - After the last EMIT of each word, the block enters SCRUB for one cycle with L_we=1, L_data_o=0 and L_address equal to that word.
  - It then goes to FETCH or DONE. L is all zero after completion.
- Not defined:
  - No SCRUB state; L_we and L_data_o are tied to 0.

## Structure
- Shared package (rc5_pkg) holds:
  - state encodings (IDLE, FETCH, WAIT, EMIT, SCRUB, DONE, 3 bits)
  - the byte-order constant (little-endian)
  - the parameter defaults B/W/U/C shared with the key-loading block
- No sub-module is needed. The shift-register byte extractor stays inline.

## Test plan
- Defaults, L = {0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C}, start pulse -> key RAM holds 0x00..0x0F at addresses 0..15. done is a single pulse in cycle 26 and busy falls with it.
- B=10, C=3, L[2]=0xDDCCBBAA -> K[8]=0xAA, K[9]=0xBB. Exactly 10 key_we cycles and no write to addresses >= 10.
- Round trip: load a random 16-byte key with the key-loading block, then run l_unpack -> identical bytes.
- Assert rst during the second word's EMIT -> all outputs 0 the next cycle and no key_we afterwards. A new start then completes normally.
- start re-pulsed at cycles 5 and 26 -> ignored. Exactly 16 writes occur and there is one done pulse.
- With L_UNPACK_SCRUB_EN -> 4 L_we pulses with data 0 at addresses 0..3, and done at cycle 30. Without it, L_we is never high.
